// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider / tick generator.
// Each channel runs an interval counter; reconfiguration is double-buffered and applied at a boundary.
module clk_div_multi #(
  parameter int N_CH         = 4,
  parameter int WIDTH        = 29,
  parameter int CH_W         = 2,
  parameter int DEFAULT_HALF = 25000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_CH-1:0]   en,
  input  logic              sync,
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [WIDTH-1:0]  wr_half,
  input  logic              wr_mode,
  output logic [N_CH-1:0]   clk_out,
  output logic [N_CH-1:0]   tick
);

  localparam logic [WIDTH-1:0] DEF_HALF = WIDTH'(DEFAULT_HALF);

  logic [WIDTH-1:0] cnt    [N_CH];
  logic [WIDTH-1:0] half_a [N_CH];
  logic [WIDTH-1:0] half_s [N_CH];
  logic [N_CH-1:0]  mode_a;
  logic [N_CH-1:0]  mode_s;
  logic [N_CH-1:0]  pend;
  logic [N_CH-1:0]  wr_hit;
  logic [N_CH-1:0]  term;

  // Channel indices above N_CH-1 never match, so out-of-range writes fall away.
  always_comb begin
    wr_hit = '0;
    term   = '0;
    for (int i = 0; i < N_CH; i++) begin
      wr_hit[i] = wr_en && (wr_ch == CH_W'(i));
      term[i]   = (cnt[i] == half_a[i] - WIDTH'(1));
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < N_CH; i++) begin
      if (!rst_n) begin
        cnt[i]     <= '0;
        half_a[i]  <= DEF_HALF;
        half_s[i]  <= DEF_HALF;
        mode_a[i]  <= 1'b0;
        mode_s[i]  <= 1'b0;
        pend[i]    <= 1'b0;
        clk_out[i] <= 1'b0;
        tick[i]    <= 1'b0;
      end else begin
        if (!en[i] || half_a[i] == '0) begin
          cnt[i]     <= '0;
          clk_out[i] <= 1'b0;
          tick[i]    <= 1'b0;
          if (pend[i]) begin
            half_a[i] <= half_s[i];
            mode_a[i] <= mode_s[i];
            pend[i]   <= 1'b0;
          end
        end else if (sync) begin
          // A write landing on the sync edge takes effect immediately.
          cnt[i]     <= '0;
          clk_out[i] <= 1'b0;
          tick[i]    <= 1'b0;
          pend[i]    <= 1'b0;
          if (wr_hit[i]) begin
            half_a[i] <= wr_half;
            mode_a[i] <= wr_mode;
            half_s[i] <= wr_half;
            mode_s[i] <= wr_mode;
          end else if (pend[i]) begin
            half_a[i] <= half_s[i];
            mode_a[i] <= mode_s[i];
          end
        end else if (term[i]) begin
          cnt[i] <= '0;
          if (mode_a[i]) begin
            clk_out[i] <= 1'b0;
            tick[i]    <= 1'b1;
          end else begin
            clk_out[i] <= ~clk_out[i];
            tick[i]    <= ~clk_out[i];
          end
          if (pend[i]) begin
            half_a[i] <= half_s[i];
            mode_a[i] <= mode_s[i];
            pend[i]   <= 1'b0;
            if (mode_s[i] != mode_a[i]) clk_out[i] <= 1'b0;
          end
        end else begin
          cnt[i]  <= cnt[i] + WIDTH'(1);
          tick[i] <= 1'b0;
        end
        // Later assignment wins: a same-edge write re-arms the shadow after any application.
        if (wr_hit[i] && !(en[i] && sync && half_a[i] != '0)) begin
          half_s[i] <= wr_half;
          mode_s[i] <= wr_mode;
          pend[i]   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed plus randomized bench for clk_div_multi, checked every cycle against an interval model.
module tb_clk_div_multi;
  localparam int N   = 3;
  localparam int W   = 8;
  localparam int CW  = 2;
  localparam int DEF = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  en = '0;
  logic          sync = 1'b0;
  logic          wr_en = 1'b0;
  logic [CW-1:0] wr_ch = '0;
  logic [W-1:0]  wr_half = '0;
  logic          wr_mode = 1'b0;
  logic [N-1:0]  clk_out;
  logic [N-1:0]  tick;

  clk_div_multi #(.N_CH(N), .WIDTH(W), .CH_W(CW), .DEFAULT_HALF(DEF)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .sync(sync), .wr_en(wr_en), .wr_ch(wr_ch),
    .wr_half(wr_half), .wr_mode(wr_mode), .clk_out(clk_out), .tick(tick)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Model: each channel counts down the edges remaining until its next event.
  int m_rem [N];
  int m_half [N];
  int m_mode [N];
  int m_sh_half [N];
  int m_sh_mode [N];
  int m_pend [N];
  int m_out [N];
  int m_tick [N];

  task automatic model_step();
    for (int c = 0; c < N; c++) begin
      bit hit;
      hit = wr_en && (int'(wr_ch) == c);
      if (!rst_n) begin
        m_half[c] = DEF; m_mode[c] = 0; m_sh_half[c] = DEF; m_sh_mode[c] = 0;
        m_pend[c] = 0; m_out[c] = 0; m_tick[c] = 0; m_rem[c] = DEF;
        hit = 0;
      end else if (!en[c] || sync || m_half[c] == 0) begin
        if (en[c] && sync && m_half[c] != 0 && hit) begin
          m_sh_half[c] = int'(wr_half); m_sh_mode[c] = int'(wr_mode); m_pend[c] = 1;
          hit = 0;
        end
        if (m_pend[c] != 0) begin
          m_half[c] = m_sh_half[c]; m_mode[c] = m_sh_mode[c]; m_pend[c] = 0;
        end
        m_out[c] = 0; m_tick[c] = 0; m_rem[c] = m_half[c];
      end else begin
        m_rem[c]--;
        m_tick[c] = 0;
        if (m_rem[c] == 0) begin
          if (m_mode[c] == 0) begin
            m_out[c] = 1 - m_out[c]; m_tick[c] = m_out[c];
          end else begin
            m_out[c] = 0; m_tick[c] = 1;
          end
          if (m_pend[c] != 0) begin
            if (m_sh_mode[c] != m_mode[c]) m_out[c] = 0;
            m_half[c] = m_sh_half[c]; m_mode[c] = m_sh_mode[c]; m_pend[c] = 0;
          end
          m_rem[c] = m_half[c];
        end
      end
      if (hit) begin
        m_sh_half[c] = int'(wr_half); m_sh_mode[c] = int'(wr_mode); m_pend[c] = 1;
      end
    end
  endtask

  task automatic cycle();
    logic [N-1:0] e_out, e_tick;
    model_step();
    @(posedge clk);
    #1;
    for (int c = 0; c < N; c++) begin
      e_out[c]  = (m_out[c] != 0);
      e_tick[c] = (m_tick[c] != 0);
    end
    tests++;
    assert (clk_out === e_out) else begin
      fails++;
      $error("FAIL clk_out t=%0t got %b exp %b", $time, clk_out, e_out);
    end
    tests++;
    assert (tick === e_tick) else begin
      fails++;
      $error("FAIL tick t=%0t got %b exp %b", $time, tick, e_tick);
    end
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic do_write(input int ch, input int h, input int md);
    wr_en = 1'b1; wr_ch = CW'(ch); wr_half = W'(h); wr_mode = md[0];
    cycle();
    wr_en = 1'b0;
  endtask

  initial begin
    int first;
    int budget_ok;
    int k;

    // Reset held with all channels enabled.
    rst_n = 1'b0; en = '1;
    run(3);
    tests++;
    assert (clk_out === '0 && tick === '0) else begin
      fails++;
      $error("FAIL reset_out got %b/%b exp 000/000", clk_out, tick);
    end

    // Default half: first toggle on the 5th edge after release.
    rst_n = 1'b1;
    first = 0;
    for (int i = 1; i <= 12; i++) begin
      cycle();
      if (clk_out[0] && first == 0) first = i;
    end
    tests++;
    assert (first === DEF) else begin
      fails++;
      $error("FAIL default_first_toggle got %0d exp %0d", first, DEF);
    end

    // Square ch0 half 3, pulse ch1 half 4.
    rst_n = 1'b0; run(1); rst_n = 1'b1; en = '0;
    do_write(0, 3, 0);
    do_write(1, 4, 1);
    run(1);
    en = 3'b011;
    run(24);

    // Boundary update: write half 5 when ch0 is one edge into its interval.
    budget_ok = 0;
    for (k = 0; k < 20; k++) begin
      if (m_rem[0] == 2) begin budget_ok = 1; break; end
      cycle();
    end
    tests++;
    assert (budget_ok == 1) else begin
      fails++;
      $error("FAIL wait_cnt1 budget expired got %0d exp 1", budget_ok);
    end
    do_write(0, 5, 0);
    run(20);
    do_write(0, 7, 0);
    do_write(0, 2, 0);
    run(20);

    // Sync alignment of ch0 and ch2.
    en = '0; run(1);
    do_write(0, 4, 0);
    do_write(2, 4, 0);
    run(1);
    en = 3'b001; run(2);
    en = 3'b101; run(5);
    sync = 1'b1; run(1); sync = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cycle();
      tests++;
      assert (clk_out[0] === clk_out[2]) else begin
        fails++;
        $error("FAIL sync_align got %b exp %b", clk_out[2], clk_out[0]);
      end
    end

    // Out-of-range channel, half 0 idle, half 1 square on ch1.
    en = 3'b111;
    do_write(3, 9, 1);
    run(10);
    do_write(0, 0, 0);
    run(10);
    tests++;
    assert (clk_out[0] === 1'b0 && tick[0] === 1'b0) else begin
      fails++;
      $error("FAIL idle_ch0 got %b%b exp 00", clk_out[0], tick[0]);
    end
    do_write(1, 1, 0);
    run(10);

    // Disable ch1 two edges into a half-5 interval.
    do_write(1, 5, 0);
    budget_ok = 0;
    for (k = 0; k < 30; k++) begin
      if (m_half[1] == 5 && m_rem[1] == 3) begin budget_ok = 1; break; end
      cycle();
    end
    tests++;
    assert (budget_ok == 1) else begin
      fails++;
      $error("FAIL wait_cnt2 budget expired got %0d exp 1", budget_ok);
    end
    en[1] = 1'b0; run(1);
    en[1] = 1'b1; run(12);

    // Reset with a pending write restores the default half.
    do_write(2, 9, 1);
    rst_n = 1'b0; run(1); rst_n = 1'b1;
    run(12);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      for (int c = 0; c < N; c++) en[c] = ($urandom_range(0, 99) < 88);
      sync    = ($urandom_range(0, 99) < 4);
      wr_en   = ($urandom_range(0, 99) < 15);
      wr_ch   = CW'($urandom_range(0, 3));
      wr_half = W'($urandom_range(0, 7));
      wr_mode = $urandom_range(0, 1) == 1;
      cycle();
    end
    wr_en = 1'b0; sync = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/clk_div_multi.md
Name: clk_div_multi

Overview:
- Multi-channel programmable clock divider and tick generator running off the 50 MHz board clock.
- Each of N channels has its own half-period, enable and mode: square-wave toggle output or single-cycle tick strobe.
- Channels are reconfigured at runtime through a one-cycle write port; the new value is applied glitch-free at the channel's next boundary.
- A global sync input phase-aligns all channels. Used for display scan, buzzer tones and dispenser motor step timing.

Parameters:
- N_CH, 4, number of independent divider channels (1..16).
- WIDTH, 29, width of half-period values and counters.
- CH_W, 2, width of the channel select; must satisfy 2^CH_W >= N_CH.
- DEFAULT_HALF, 25000000, half-period loaded into every channel at reset (1 Hz square at 50 MHz).

Ports:
- clk  in  1  system clock, 50 MHz.
- rst_n  in  1  synchronous active-low reset.
- en  in  N_CH  per-channel run enable.
- sync  in  1  one-cycle strobe; restarts all channels in phase.
- wr_en  in  1  configuration write strobe.
- wr_ch  in  CH_W  target channel of the write.
- wr_half  in  WIDTH  new half-period, in clk cycles (0 = stop channel).
- wr_mode  in  1  new mode: 0 = square, 1 = pulse.
- clk_out  out  N_CH  divided square outputs, registered.
- tick  out  N_CH  one-cycle strobes, registered.

Behaviour:
- Reset
  - One clock; reset is synchronous and active-low.
  - While rst_n = 0 at a clk edge: all counters = 0; active half = DEFAULT_HALF; shadow half = DEFAULT_HALF; mode = 0 for every channel; clk_out = 0; tick = 0.
  - A reset mid-operation discards any pending shadow value.
- Per-channel state
  - cnt[WIDTH], active half, active mode, shadow half, shadow mode, pending flag.
- Counting (channel enabled, active half != 0)
  - On every edge: if cnt == half-1, then cnt <= 0 and a terminal event occurs; else cnt <= cnt+1.
- Square mode
  - clk_out toggles on each terminal event; output period = 2*half cycles, 50% duty.
  - tick pulses high for one cycle on the edge where clk_out goes 0->1.
- Pulse mode
  - clk_out is held at 0.
  - tick is high for exactly one cycle per terminal event, i.e. once every half cycles.
- Timing and latency
  - First event occurs half edges after the first edge that samples en = 1.
  - Outputs are registered; no combinational path from inputs to outputs.
- half = 1
  - Square mode gives clk/2.
  - Pulse mode holds tick continuously high.
- Disable
  - An edge sampling en[i] = 0 forces cnt = 0, clk_out[i] = 0, tick[i] = 0.
  - If pending, the shadow is copied to active at that edge.
- Config write
  - wr_en = 1 with wr_ch < N_CH loads the shadow half and mode and sets pending.
  - wr_ch >= N_CH: write ignored.
  - A second write before application overwrites the shadow (last write wins).
- Application of pending shadow, at the first of:
  - the channel's terminal event: the new half governs the next interval, and the output toggles/pulses normally at that event;
  - the channel being disabled;
  - active half == 0;
  - sync.
- Mode change on application
  - clk_out forced to 0 at the same edge; no runt pulse.
- half = 0 active
  - Channel idle: cnt held at 0, outputs 0; the channel still accepts writes.
- Sync
  - At the sync edge: every enabled channel gets cnt = 0, clk_out = 0, tick = 0, and pending shadows applied.
  - All channels with equal half then produce identical outputs.
- Simultaneous events
  - rst_n = 0 overrides everything.
  - en = 0 overrides sync and counting.
  - A write and sync on the same edge: the written value is applied at that sync edge.
  - A write on the same edge as a terminal event: the write lands in the shadow and is applied at the next terminal event, not the current one.
- Arithmetic
  - Unsigned compare only; cnt never exceeds half-1, so it cannot wrap.

Test Plan:
- Reset and default half: hold rst_n = 0 for 3 cycles with en = 0xF -> all outputs 0. Then run with default half -> clk_out[0] first toggles 25000000 cycles after release (use WIDTH = 8, DEFAULT_HALF = 5 in the bench: toggle after 5 cycles, period 10).
- Square and pulse: ch0 half = 3 mode 0 -> clk_out[0] high 3 / low 3, tick[0] one cycle per 6. ch1 half = 4 mode 1 -> tick[1] one cycle every 4, clk_out[1] = 0.
- Boundary update: ch0 running half = 3, write half = 5 mid-interval (cnt = 1) -> current interval completes at 3, the following intervals are 5. Back-to-back writes 7 then 2 -> 2 applied.
- Sync alignment: ch0 and ch2 both half = 4, enabled 2 cycles apart; pulse sync -> from the next edge clk_out[0] == clk_out[2] for 40 cycles.
- Edge cases: write wr_ch = 3 with N_CH = 3 -> no state change. Write half = 0 -> channel goes idle at its next event, outputs 0. half = 1 square -> clk/2.
- Disable/reset mid-run: drop en[1] at cnt = 2 -> next edge outputs 0, cnt 0; re-enable -> first event after half cycles. Assert rst_n = 0 with a pending write -> the pending write is discarded and DEFAULT_HALF is restored.
